// File: rtl/lu_arith_arbiter.sv
// ============================================================================
// lu_arith_arbiter
// Round-robin arbiter sharing one multiplier and one divider among NREQ
// requesters, with a watchdog that converts a hung unit into an error response.
// Rev 1.0
// ============================================================================
`default_nettype none

module lu_arith_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ-1:0]         req_op_i,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic [WIDTH-1:0]        rsp_val_o,
    output logic                    rsp_ovf_o,
    output logic                    rsp_dbz_o,
    output logic                    rsp_tmo_o,
    output logic                    mul_start_o,
    output logic [WIDTH-1:0]        mul_a_o,
    output logic [WIDTH-1:0]        mul_b_o,
    input  logic                    mul_done_i,
    input  logic [WIDTH-1:0]        mul_val_i,
    input  logic                    mul_ovf_i,
    output logic                    div_start_o,
    output logic [WIDTH-1:0]        div_a_o,
    output logic [WIDTH-1:0]        div_b_o,
    input  logic                    div_done_i,
    input  logic [WIDTH-1:0]        div_val_i,
    input  logic                    div_ovf_i,
    input  logic                    div_dbz_i,
    output logic                    busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    gnt_q;
    logic             op_q;
    logic [NREQ-1:0]  req_ready_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [WIDTH-1:0] rsp_val_q;
    logic             rsp_ovf_q;
    logic             rsp_dbz_q;
    logic             rsp_tmo_q;
    logic             mul_start_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic             div_start_q;
    logic [WIDTH-1:0] div_a_q;
    logic [WIDTH-1:0] div_b_q;

    logic             w_found;
    logic [PW-1:0]    w_gnt;
    logic [PW-1:0]    w_idx;
    logic [NREQ-1:0]  w_gnt_oh;
    logic [NREQ-1:0]  w_cur_oh;
    logic             w_sel_done;
    logic             w_wd_exp;

    // Search starts at rr_ptr and wraps, so the first hit is the fair winner.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_gnt_oh   = NREQ'(1) << w_gnt;
    assign w_cur_oh   = NREQ'(1) << gnt_q;
    assign w_sel_done = op_q ? div_done_i : mul_done_i;
    assign w_wd_exp   = (wd_q == WW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (w_sel_done || w_wd_exp) begin
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                wd_d     = '0;
                rr_ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wd_q        <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op_q        <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_val_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_dbz_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        gnt_q       <= w_gnt;
                        op_q        <= req_op_i[w_gnt];
                        req_ready_q <= w_gnt_oh;
                        rsp_ovf_q   <= 1'b0;
                        rsp_dbz_q   <= 1'b0;
                        rsp_tmo_q   <= 1'b0;
                        // Only the selected unit's operands move.
                        if (req_op_i[w_gnt]) begin
                            div_a_q <= req_a_i[w_gnt*WIDTH +: WIDTH];
                            div_b_q <= req_b_i[w_gnt*WIDTH +: WIDTH];
                        end else begin
                            mul_a_q <= req_a_i[w_gnt*WIDTH +: WIDTH];
                            mul_b_q <= req_b_i[w_gnt*WIDTH +: WIDTH];
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_q) begin
                        div_start_q <= 1'b1;
                    end else begin
                        mul_start_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_sel_done) begin
                        rsp_val_q <= op_q ? div_val_i : mul_val_i;
                        rsp_ovf_q <= op_q ? div_ovf_i : mul_ovf_i;
                        rsp_dbz_q <= op_q & div_dbz_i;
                        rsp_tmo_q <= 1'b0;
                    end else if (w_wd_exp) begin
                        rsp_val_q <= '0;
                        rsp_ovf_q <= 1'b0;
                        rsp_dbz_q <= 1'b0;
                        rsp_tmo_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= w_cur_oh;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_val_o   = rsp_val_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign rsp_dbz_o   = rsp_dbz_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign mul_start_o = mul_start_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign div_start_o = div_start_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lu_arith_arbiter.sv
// ============================================================================
// tb_lu_arith_arbiter
// Directed self-checking bench with simple multiplier/divider models.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lu_arith_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 64;
    localparam int MLAT = 2;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_op;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ-1:0]  rsp_valid;
    logic [W-1:0]     rsp_val;
    logic             rsp_ovf, rsp_dbz, rsp_tmo;
    logic             mul_start, mul_done, mul_ovf;
    logic [W-1:0]     mul_a, mul_b, mul_val;
    logic             div_start, div_done, div_ovf, div_dbz;
    logic [W-1:0]     div_a, div_b, div_val;
    logic             busy;

    lu_arith_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_val_o(rsp_val),
        .rsp_ovf_o(rsp_ovf), .rsp_dbz_o(rsp_dbz), .rsp_tmo_o(rsp_tmo),
        .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_done_i(mul_done), .mul_val_i(mul_val), .mul_ovf_i(mul_ovf),
        .div_start_o(div_start), .div_a_o(div_a), .div_b_o(div_b),
        .div_done_i(div_done), .div_val_i(div_val), .div_ovf_i(div_ovf), .div_dbz_i(div_dbz),
        .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus-side controls (written only by the main process)
    int   dlat;
    logic div_hang;
    logic inj_mul_tgl, inj_div_tgl;

    // Model-side state (written only by the model process)
    int   mcnt, dcnt, n_mul_start, n_div_start, p, q;
    logic signed [W-1:0] ma, mb, da, db;
    logic mul_seen, div_seen;

    // Unit models act half a cycle away from the DUT's active edge.
    initial begin
        mul_done = 1'b0; mul_val = '0; mul_ovf = 1'b0;
        div_done = 1'b0; div_val = '0; div_ovf = 1'b0; div_dbz = 1'b0;
        mcnt = 0; dcnt = 0; n_mul_start = 0; n_div_start = 0;
        mul_seen = 1'b0; div_seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            mul_done = 1'b0;
            div_done = 1'b0;
            if (mul_start) begin
                n_mul_start++;
                ma = mul_a; mb = mul_b; mcnt = MLAT;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    p        = (int'(ma) * int'(mb)) >>> 4;
                    mul_val  = p[W-1:0];
                    mul_ovf  = (p > 32767) || (p < -32768);
                    mul_done = 1'b1;
                end
            end
            if (div_start) begin
                n_div_start++;
                da = div_a; db = div_b; dcnt = dlat;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0 && !div_hang) begin
                    if (db == 0) begin
                        div_val = '0; div_ovf = 1'b0; div_dbz = 1'b1;
                    end else begin
                        q       = (int'(da) * 16) / int'(db);
                        div_val = q[W-1:0];
                        div_ovf = (q > 32767) || (q < -32768);
                        div_dbz = 1'b0;
                    end
                    div_done = 1'b1;
                end
            end
            if (inj_mul_tgl != mul_seen) begin
                mul_seen = inj_mul_tgl;
                mul_done = 1'b1; mul_val = 16'h7777; mul_ovf = 1'b1;
            end
            if (inj_div_tgl != div_seen) begin
                div_seen = inj_div_tgl;
                div_done = 1'b1; div_val = 16'h1234; div_ovf = 1'b1; div_dbz = 1'b0;
            end
        end
    end

    int n_vec, n_err;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [NREQ-1:0] r_rdy, r_rsp;
    logic [W-1:0]    r_val;
    logic [2:0]      r_flags;
    int              r_cyc;

    task automatic wait_ready();
        int ok = 0;
        for (int c = 0; c < 100 && ok == 0; c++) begin
            @(negedge clk);
            if (req_ready != '0) ok = 1;
        end
        r_rdy = req_ready;
        if (ok == 0) chk_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input int idx, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        req_valid[idx]      = 1'b1;
        req_op[idx]         = op;
        req_a[idx*W +: W]   = a;
        req_b[idx*W +: W]   = b;
        wait_ready();
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int start);
        int ok = 0;
        r_cyc = start;
        for (int c = 0; c < 300 && ok == 0; c++) begin
            @(negedge clk);
            r_cyc++;
            if (rsp_valid != '0) ok = 1;
        end
        r_rsp   = rsp_valid;
        r_val   = rsp_val;
        r_flags = {rsp_ovf, rsp_dbz, rsp_tmo};
        if (ok == 0) chk_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    int nm, nd;
    logic [NREQ-1:0] seen;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        dlat = 3; div_hang = 1'b0; inj_mul_tgl = 1'b0; inj_div_tgl = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("reset_busy", {31'd0, busy}, 32'd0);
        chk_eq("reset_strobes", {24'd0, req_ready, rsp_valid}, 32'd0);
        rst = 1'b1;

        // Reset during a divide in WAIT discards it
        dlat = 8;
        issue(1, 1'b1, 16'h0060, 16'h0020);
        repeat (3) @(negedge clk);
        chk_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk_eq("mid_rst_outs", {31'd0, |{busy, req_ready, rsp_valid, mul_start, div_start,
               mul_a, mul_b, div_a, div_b, rsp_val, rsp_ovf, rsp_dbz, rsp_tmo}}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk_eq("mid_rst_no_rsp", {28'd0, seen}, 32'd0);

        // Multiply 2.0 * 3.0
        nm = n_mul_start; nd = n_div_start;
        issue(0, 1'b0, 16'h0020, 16'h0030);
        chk_eq("mul_ready", {28'd0, r_rdy}, 32'h1);
        wait_rsp(0);
        chk_eq("mul_rsp_valid", {28'd0, r_rsp}, 32'h1);
        chk_eq("mul_rsp_val", {16'd0, r_val}, 32'h0060);
        chk_eq("mul_flags", {29'd0, r_flags}, 32'h0);
        chk_eq("mul_latency", r_cyc, MLAT + 3);
        chk_eq("mul_starts", n_mul_start - nm, 32'd1);
        chk_eq("mul_no_div_start", n_div_start - nd, 32'd0);

        // Divide by zero
        dlat = 3;
        nm = n_mul_start; nd = n_div_start;
        issue(1, 1'b1, 16'h0060, 16'h0000);
        chk_eq("dbz_ready", {28'd0, r_rdy}, 32'h2);
        wait_rsp(0);
        chk_eq("dbz_rsp_valid", {28'd0, r_rsp}, 32'h2);
        chk_eq("dbz_flags", {29'd0, r_flags}, 32'h2);
        chk_eq("dbz_latency", r_cyc, 32'd6);
        chk_eq("dbz_no_mul_start", n_mul_start - nm, 32'd0);
        chk_eq("dbz_div_starts", n_div_start - nd, 32'd1);

        // Normal divide 6.0 / 2.0; multiplier operands untouched
        issue(2, 1'b1, 16'h0060, 16'h0020);
        chk_eq("div_ready", {28'd0, r_rdy}, 32'h4);
        wait_rsp(0);
        chk_eq("div_rsp_val", {16'd0, r_val}, 32'h0030);
        chk_eq("div_mul_ops_kept", {mul_a, mul_b}, 32'h0020_0030);

        // All four held valid from reset: strict rotation
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        req_op = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'((i + 1) * 16);
            req_b[i*W +: W] = 16'h0010;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ready();
            chk_eq("rr_grant", {28'd0, r_rdy}, 32'd1 << (k % 4));
            wait_rsp(0);
            chk_eq("rr_rsp", {28'd0, r_rsp}, {28'd0, r_rdy});
            if (k == 7) req_valid = '0;
        end

        // Divider hangs: watchdog response, late done ignored
        div_hang = 1'b1;
        issue(3, 1'b1, 16'h0010, 16'h0010);
        chk_eq("tmo_ready", {28'd0, r_rdy}, 32'h8);
        wait_rsp(0);
        chk_eq("tmo_rsp_valid", {28'd0, r_rsp}, 32'h8);
        chk_eq("tmo_flags", {29'd0, r_flags}, 32'h1);
        chk_eq("tmo_rsp_val", {16'd0, r_val}, 32'h0);
        chk_eq("tmo_latency", r_cyc, TO + 2);
        inj_div_tgl = ~inj_div_tgl;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk_eq("tmo_late_done", {12'd0, seen, rsp_val}, 32'h0);
        div_hang = 1'b0;

        // Spurious multiplier done during a divide
        dlat = 8;
        issue(0, 1'b1, 16'h0030, 16'h0010);
        repeat (2) @(negedge clk);
        inj_mul_tgl = ~inj_mul_tgl;
        wait_rsp(2);
        chk_eq("spur_rsp_valid", {28'd0, r_rsp}, 32'h1);
        chk_eq("spur_rsp_val", {16'd0, r_val}, 32'h0030);
        chk_eq("spur_flags", {29'd0, r_flags}, 32'h0);
        chk_eq("spur_latency", r_cyc, 32'd11);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
